// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file with per-bit write masks, optional
// same-cycle write-to-read bypass and optional registered read ports.
module regfile_multiport #(
  parameter int               WIDTH        = 4,
  parameter int               DEPTH        = 4,
  parameter int               NUM_READ     = 2,
  parameter int               NUM_WRITE    = 2,
  parameter int               READ_LATENCY = 0,
  parameter int               BYPASS       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  localparam int              AW           = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_READ*AW-1:0]     read_addr,
  output logic [NUM_READ*WIDTH-1:0]  read_data,
  input  logic [NUM_WRITE*AW-1:0]    write_addr,
  input  logic [NUM_WRITE*WIDTH-1:0] write_data,
  input  logic [NUM_WRITE*WIDTH-1:0] write_mask,
  input  logic [NUM_WRITE-1:0]       write_en
);

  logic [WIDTH-1:0]          mem      [DEPTH];
  logic [WIDTH-1:0]          next_mem [DEPTH];
  logic [NUM_READ*WIDTH-1:0] read_val;

  // Later ports are applied last, so the highest-index port wins per mask bit.
  // Addresses at or beyond DEPTH never match an entry and are dropped.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      next_mem[e] = mem[e];
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (write_en[j] && (write_addr[j*AW +: AW] == AW'(e))) begin
          next_mem[e] = (next_mem[e] & ~write_mask[j*WIDTH +: WIDTH])
                      | (write_data[j*WIDTH +: WIDTH] & write_mask[j*WIDTH +: WIDTH]);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (RESET) begin
        mem[e] <= RESET_VALUE;
      end else begin
        mem[e] <= next_mem[e];
      end
    end
  end

  // Bypass reads see the post-edge value of the entry; suppressed during reset.
  always_comb begin
    read_val = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (read_addr[i*AW +: AW] == AW'(e)) begin
          read_val[i*WIDTH +: WIDTH] = ((BYPASS != 0) && !RESET) ? next_mem[e] : mem[e];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_reg_read
      logic [NUM_READ*WIDTH-1:0] read_q;

      always_ff @(posedge CLK) begin
        if (RESET) begin
          read_q <= {NUM_READ{RESET_VALUE}};
        end else begin
          read_q <= read_val;
        end
      end

      assign read_data = read_q;
    end else begin : g_comb_read
      assign read_data = read_val;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed-vector bench for regfile_multiport: four 4x4 configurations share
// one stimulus bus, plus a DEPTH=5/WIDTH=8 instance for out-of-range addresses.
module tb_regfile_multiport;

  logic       CLK;
  logic       rst;
  logic [3:0] ra;
  logic [3:0] wa;
  logic [7:0] wd;
  logic [7:0] wm;
  logic [1:0] we;
  logic [7:0] d_rd;
  logic [7:0] n_rd;
  logic [7:0] r_rd;
  logic [7:0] q_rd;

  logic [5:0]  p_ra;
  logic [15:0] p_rd;
  logic [5:0]  p_wa;
  logic [15:0] p_wd;
  logic [15:0] p_wm;
  logic [1:0]  p_we;

  int check_count;
  int pass_count;

  // d: bypass comb, n: no-bypass comb, r: registered no-bypass, q: registered bypass
  regfile_multiport u_def (
    .CLK(CLK), .RESET(rst), .read_addr(ra), .read_data(d_rd),
    .write_addr(wa), .write_data(wd), .write_mask(wm), .write_en(we)
  );

  regfile_multiport #(.BYPASS(0)) u_nb (
    .CLK(CLK), .RESET(rst), .read_addr(ra), .read_data(n_rd),
    .write_addr(wa), .write_data(wd), .write_mask(wm), .write_en(we)
  );

  regfile_multiport #(.READ_LATENCY(1), .BYPASS(0)) u_rl (
    .CLK(CLK), .RESET(rst), .read_addr(ra), .read_data(r_rd),
    .write_addr(wa), .write_data(wd), .write_mask(wm), .write_en(we)
  );

  regfile_multiport #(.READ_LATENCY(1), .BYPASS(1)) u_rb (
    .CLK(CLK), .RESET(rst), .read_addr(ra), .read_data(q_rd),
    .write_addr(wa), .write_data(wd), .write_mask(wm), .write_en(we)
  );

  regfile_multiport #(.DEPTH(5), .WIDTH(8)) u_np (
    .CLK(CLK), .RESET(rst), .read_addr(p_ra), .read_data(p_rd),
    .write_addr(p_wa), .write_data(p_wd), .write_mask(p_wm), .write_en(p_we)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_wr(input int port, input logic [1:0] a, input logic [3:0] d, input logic [3:0] m);
    wa[port*2 +: 2] = a;
    wd[port*4 +: 4] = d;
    wm[port*4 +: 4] = m;
    we[port]        = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_wr(0, 2'd0, 4'h1, 4'hF);
    set_wr(1, 2'd1, 4'h2, 4'hF);
    tick();
    set_wr(0, 2'd2, 4'h3, 4'hF);
    set_wr(1, 2'd3, 4'h4, 4'hF);
    tick();
    we = 2'b00;
    ra = {2'd1, 2'd0};
    #1;
    check_count++;
    if (d_rd !== 8'h21) $display("[TB] FAIL preload_lo got %h expected %h", d_rd, 8'h21);
    else pass_count++;
    ra = {2'd3, 2'd2};
    #1;
    check_count++;
    if (d_rd !== 8'h43) $display("[TB] FAIL preload_hi got %h expected %h", d_rd, 8'h43);
    else pass_count++;
    check_count++;
    if (n_rd !== 8'h43) $display("[TB] FAIL preload_hi_nb got %h expected %h", n_rd, 8'h43);
    else pass_count++;
    // write during reset must be ignored and must not bypass
    rst = 1'b1;
    set_wr(0, 2'd0, 4'hF, 4'hF);
    ra = {2'd1, 2'd0};
    #1;
    check_count++;
    if (d_rd !== 8'h21) $display("[TB] FAIL reset_cycle_read got %h expected %h", d_rd, 8'h21);
    else pass_count++;
    tick();
    rst = 1'b0;
    we = 2'b00;
    #1;
    check_count++;
    if (d_rd !== 8'h00) $display("[TB] FAIL reset_lo got %h expected %h", d_rd, 8'h00);
    else pass_count++;
    check_count++;
    if (r_rd !== 8'h00) $display("[TB] FAIL reset_rl got %h expected %h", r_rd, 8'h00);
    else pass_count++;
    check_count++;
    if (q_rd !== 8'h00) $display("[TB] FAIL reset_rb got %h expected %h", q_rd, 8'h00);
    else pass_count++;
    ra = {2'd3, 2'd2};
    #1;
    check_count++;
    if (d_rd !== 8'h00) $display("[TB] FAIL reset_hi got %h expected %h", d_rd, 8'h00);
    else pass_count++;
  endtask

  task automatic test_bypass();
    set_wr(0, 2'd2, 4'hA, 4'hF);
    ra = {2'd3, 2'd2};
    #1;
    check_count++;
    if (d_rd !== 8'h0A) $display("[TB] FAIL bypass_same_cycle got %h expected %h", d_rd, 8'h0A);
    else pass_count++;
    check_count++;
    if (n_rd !== 8'h00) $display("[TB] FAIL nobypass_same_cycle got %h expected %h", n_rd, 8'h00);
    else pass_count++;
    tick();
    check_count++;
    if (q_rd !== 8'h0A) $display("[TB] FAIL reg_bypass got %h expected %h", q_rd, 8'h0A);
    else pass_count++;
    check_count++;
    if (r_rd !== 8'h00) $display("[TB] FAIL reg_old_data got %h expected %h", r_rd, 8'h00);
    else pass_count++;
    we = 2'b00;
    #1;
    check_count++;
    if (n_rd !== 8'h0A) $display("[TB] FAIL nobypass_next_cycle got %h expected %h", n_rd, 8'h0A);
    else pass_count++;
    tick();
    check_count++;
    if (r_rd !== 8'h0A) $display("[TB] FAIL reg_new_data got %h expected %h", r_rd, 8'h0A);
    else pass_count++;
  endtask

  task automatic test_collision();
    ra = {2'd1, 2'd1};
    set_wr(0, 2'd1, 4'h3, 4'hF);
    set_wr(1, 2'd1, 4'h8, 4'hC);
    #1;
    check_count++;
    if (d_rd !== 8'hBB) $display("[TB] FAIL collision_bypass got %h expected %h", d_rd, 8'hBB);
    else pass_count++;
    tick();
    we = 2'b00;
    #1;
    check_count++;
    if (n_rd !== 8'hBB) $display("[TB] FAIL collision_stored got %h expected %h", n_rd, 8'hBB);
    else pass_count++;
    // partial mask clears only bit 0
    set_wr(1, 2'd1, 4'h0, 4'h1);
    #1;
    check_count++;
    if (d_rd !== 8'hAA) $display("[TB] FAIL partial_mask_bypass got %h expected %h", d_rd, 8'hAA);
    else pass_count++;
    tick();
    we = 2'b00;
    #1;
    check_count++;
    if (n_rd !== 8'hAA) $display("[TB] FAIL partial_mask_stored got %h expected %h", n_rd, 8'hAA);
    else pass_count++;
    ra = {2'd0, 2'd0};
    set_wr(0, 2'd0, 4'h8, 4'hC);
    set_wr(1, 2'd0, 4'h3, 4'hF);
    #1;
    check_count++;
    if (d_rd !== 8'h33) $display("[TB] FAIL priority_bypass got %h expected %h", d_rd, 8'h33);
    else pass_count++;
    tick();
    we = 2'b00;
    #1;
    check_count++;
    if (n_rd !== 8'h33) $display("[TB] FAIL priority_stored got %h expected %h", n_rd, 8'h33);
    else pass_count++;
  endtask

  task automatic test_registered();
    set_wr(0, 2'd3, 4'h5, 4'hF);
    tick();
    we = 2'b00;
    set_wr(0, 2'd3, 4'h6, 4'hF);
    ra = {2'd3, 2'd3};
    tick();
    check_count++;
    if (r_rd !== 8'h55) $display("[TB] FAIL reg_read_old got %h expected %h", r_rd, 8'h55);
    else pass_count++;
    check_count++;
    if (q_rd !== 8'h66) $display("[TB] FAIL reg_read_bypass got %h expected %h", q_rd, 8'h66);
    else pass_count++;
    we = 2'b00;
    tick();
    check_count++;
    if (r_rd !== 8'h66) $display("[TB] FAIL reg_read_new got %h expected %h", r_rd, 8'h66);
    else pass_count++;
  endtask

  task automatic test_out_of_range();
    p_wm = 16'hFFFF;
    p_we = 2'b11;
    p_wa = {3'd1, 3'd0};
    p_wd = {8'h11, 8'h10};
    tick();
    p_wa = {3'd3, 3'd2};
    p_wd = {8'h13, 8'h12};
    tick();
    p_wa = {3'd4, 3'd4};
    p_wd = {8'h14, 8'h14};
    tick();
    p_we = 2'b01;
    p_wa = {3'd0, 3'd6};
    p_wd = {8'h00, 8'hFF};
    p_ra = {3'd6, 3'd6};
    #1;
    check_count++;
    if (p_rd !== 16'h0000) $display("[TB] FAIL oor_bypass got %h expected %h", p_rd, 16'h0000);
    else pass_count++;
    tick();
    p_we = 2'b00;
    p_ra = {3'd1, 3'd0};
    #1;
    check_count++;
    if (p_rd !== 16'h1110) $display("[TB] FAIL oor_entries_01 got %h expected %h", p_rd, 16'h1110);
    else pass_count++;
    p_ra = {3'd3, 3'd2};
    #1;
    check_count++;
    if (p_rd !== 16'h1312) $display("[TB] FAIL oor_entries_23 got %h expected %h", p_rd, 16'h1312);
    else pass_count++;
    p_ra = {3'd7, 3'd4};
    #1;
    check_count++;
    if (p_rd !== 16'h0014) $display("[TB] FAIL oor_entry_4_addr_7 got %h expected %h", p_rd, 16'h0014);
    else pass_count++;
    p_ra = {3'd5, 3'd6};
    #1;
    check_count++;
    if (p_rd !== 16'h0000) $display("[TB] FAIL oor_read_56 got %h expected %h", p_rd, 16'h0000);
    else pass_count++;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    rst  = 1'b1;
    ra   = '0;
    wa   = '0;
    wd   = '0;
    wm   = '0;
    we   = '0;
    p_ra = '0;
    p_wa = '0;
    p_wd = '0;
    p_wm = '0;
    p_we = '0;
    $display("[TB] starting regfile_multiport directed tests");
    test_reset();
    test_bypass();
    test_collision();
    test_registered();
    test_out_of_range();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised multi-port register file: DEPTH words of WIDTH bits, NUM_WRITE write ports with per-bit write masks, and NUM_READ read ports. Reads are either combinational or registered, with optional same-cycle write-to-read bypass. A synchronous reset clears every entry. It is the general storage primitive behind pipeline register files, CSR banks and small lookup tables, replacing the single-read/single-write variant.

## Interface
Parameters:
- WIDTH, 4: bits per entry (≥1)
- DEPTH, 4: number of entries (≥2; need not be a power of two)
- NUM_READ, 2: read ports (≥1)
- NUM_WRITE, 2: write ports (≥1)
- READ_LATENCY, 0: 0 = combinational read, 1 = registered read
- BYPASS, 1: 1 = reads observe same-cycle writes; 0 = reads observe stored contents only
- RESET_VALUE, 0: WIDTH-bit value loaded into every entry and read register on reset
- AW (derived): max(1, clog2(DEPTH))

Ports (port i occupies slice [i*W +: W] of its packed bus):
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- read_addr  in  NUM_READ*AW  read addresses
- read_data  out  NUM_READ*WIDTH  read data
- write_addr  in  NUM_WRITE*AW  write addresses
- write_data  in  NUM_WRITE*WIDTH  write data
- write_mask  in  NUM_WRITE*WIDTH  per-bit write enable; 1 = bit written
- write_en  in  NUM_WRITE  per-port write strobe

## Operation
- Effective write: port j writes on an edge iff write_en[j]=1, RESET=0 and write_addr_j < DEPTH. Only bits with write_mask_j=1 change; other bits keep their value.
- Write-write collision on one address: ports are merged per bit, and the highest-index port with that mask bit set wins. Example: port 0 mask 0xF data 0x3, port 1 mask 0xC data 0x8 gives 0xB.
- Reset: while RESET=1, all writes are ignored. At the edge, every entry and every read register becomes RESET_VALUE.
- Read value V_i for read port i:
  - If read_addr_i ≥ DEPTH, V_i = 0.
  - Otherwise V_i = stored entry.
  - If BYPASS=1 and RESET=0, each bit is overridden by the highest-index effective write to the same address that has that mask bit set. This is the same merge rule as the write path, so V_i equals the value the entry will hold after the edge.
- READ_LATENCY=0: read_data_i = V_i combinationally.
- READ_LATENCY=1: read_data_i is a register loaded with V_i every edge, and with RESET_VALUE on reset edges. There is no read enable.
- Read ports are independent. Any number may address the same entry.
- No internal state exists beyond storage and the optional read registers. No FSM, no handshake, no stall.

## Timing
- Write latency: data written at edge N is visible in stored contents from edge N onward.
  - BYPASS=0, READ_LATENCY=0: visible on read_data in cycle N+1.
  - BYPASS=1, READ_LATENCY=0: visible combinationally in the write cycle itself.
- READ_LATENCY=1 adds exactly one cycle.
  - BYPASS=1: read_data after edge N reflects writes presented in cycle N.
  - BYPASS=0: read_data after edge N reflects contents before edge N, i.e. read-old-data.
- Reset values:
  - READ_LATENCY=1: read_data = RESET_VALUE in the cycle after any reset edge.
  - READ_LATENCY=0: read_data = RESET_VALUE (in-range addresses) in the cycle after reset.
  - During the RESET=1 cycle itself, combinational reads show pre-reset contents and bypass is suppressed.
- Reset for multiple cycles: contents stay RESET_VALUE, and all writes in those cycles are lost.
- No combinational path from write_* to read_data when BYPASS=0 or READ_LATENCY=1.

## Test plan
- Reset: default params; preload entries 0..3 with 0x1,0x2,0x3,0x4, pulse RESET one cycle → all reads return 0x0 next cycle; a write_en=1 issued during RESET has no effect.
- Bypass: BYPASS=1, READ_LATENCY=0; write addr 2 data 0xA mask 0xF while read port 0 reads addr 2 → read_data_0=0xA the same cycle. Repeat with BYPASS=0 → old value in that cycle, 0xA next cycle.
- Masked collision: entry 1 holds 0x0; port 0 (0x3, mask 0xF) and port 1 (0x8, mask 0xC) both write addr 1 → entry 1 = 0xB. Bypass read in the same cycle also shows 0xB.
- Registered read: READ_LATENCY=1, BYPASS=0; entry 3 = 0x5, write 0x6 to addr 3 while reading addr 3 at edge N → read_data=0x5 after N, 0x6 after N+1.
- Non-power-of-two depth: DEPTH=5, WIDTH=8; write 0xFF to addr 6 → ignored; read addr 6 → 0x00; entries 0..4 unchanged.
- Random: 10k cycles of random addresses, masks, enables and occasional RESET across (NUM_READ, NUM_WRITE, READ_LATENCY, BYPASS) ∈ {1,3}×{1,3}×{0,1}×{0,1}, compared against a cycle-accurate reference model.
